// File: rtl/riscv_dift_tag_manip_seq.sv
// riscv_dift_tag_manip_seq
// Sequential DIFT tag manipulation unit for the CV32E40P EX stage.
// Executes TAGSET and TAGRD with a registered valid/ready result port and,
// when DIFT_TAG_BULK_EN is defined, TAGBULK: a walk over a range of
// register-file tag entries through a dedicated tag write port.
// Without DIFT_TAG_BULK_EN, TAGBULK is reported as an illegal operator and
// the tag write port is tied to zero.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   enable_i, operator_i           request and opcode (000 SET, 001 RD, 010 BULK)
//   operand_a/b/c_i                32-bit operands, sampled only on accept
//   operand_a_tag_i/c_tag_i        operand tags
//   flush_i                        abort any operation, back to idle
//   ex_ready_i                     downstream accepts the result
//   ready_o, valid_o               handshake
//   result_o, result_tag_o         result data and tag
//   illegal_op_o                   accepted operator was illegal
//   rf_tag_we/waddr/wdata/wmask_o  registered tag write port (TAGBULK)
module riscv_dift_tag_manip_seq #(
  parameter int TAG_WIDTH      = 4,
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable_i,
  input  logic [2:0]                operator_i,
  input  logic [31:0]               operand_a_i,
  input  logic [31:0]               operand_b_i,
  input  logic [31:0]               operand_c_i,
  input  logic [TAG_WIDTH-1:0]      operand_a_tag_i,
  input  logic [TAG_WIDTH-1:0]      operand_c_tag_i,
  input  logic                      flush_i,
  input  logic                      ex_ready_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [31:0]               result_o,
  output logic [TAG_WIDTH-1:0]      result_tag_o,
  output logic                      illegal_op_o,
  output logic                      rf_tag_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_tag_waddr_o,
  output logic [TAG_WIDTH-1:0]      rf_tag_wdata_o,
  output logic [TAG_WIDTH-1:0]      rf_tag_wmask_o
);

  localparam logic [2:0] OP_TAGSET  = 3'b000;
  localparam logic [2:0] OP_TAGRD   = 3'b001;
  localparam logic [2:0] OP_TAGBULK = 3'b010;

`ifdef DIFT_TAG_BULK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WALK = 2'd1, S_RESP = 2'd2} state_e;
`else
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RESP = 1'b1} state_e;
`endif

  // Mask bits where set take the new value, others keep the old tag.
  function automatic logic [TAG_WIDTH-1:0] merge_tag(
    input logic [TAG_WIDTH-1:0] mask,
    input logic [TAG_WIDTH-1:0] vals,
    input logic [TAG_WIDTH-1:0] old
  );
    return (mask & vals) | (~mask & old);
  endfunction

  state_e state_q, state_d, accept_state;

  logic                 accept;
  logic                 op_bulk;
  logic                 op_illegal;
  logic [31:0]          ab_or;
  logic [TAG_WIDTH-1:0] set_tag;
  logic [31:0]          rd_word;
  logic                 walk_last;

  logic [31:0]          result_p1;
  logic [TAG_WIDTH-1:0] result_tag_p1;
  logic                 illegal_p1;

  // Upper operand bits are architecturally ignored by every operation.
  logic                 unused_operands;
  assign unused_operands = ^{operand_a_i, operand_b_i};

  assign ready_o = (state_q == S_IDLE) | ((state_q == S_RESP) & ex_ready_i);
  // Flush wins over a simultaneous request.
  assign accept  = enable_i & ready_o & ~flush_i;

`ifdef DIFT_TAG_BULK_EN
  assign op_bulk = (operator_i == OP_TAGBULK);
`else
  assign op_bulk = 1'b0;
`endif
  assign op_illegal = ~((operator_i == OP_TAGSET) | (operator_i == OP_TAGRD) | op_bulk);

  assign ab_or   = operand_a_i | operand_b_i;
  assign set_tag = merge_tag(ab_or[TAG_WIDTH-1:0], ab_or[TAG_WIDTH+7:8], operand_c_tag_i);

  always_comb begin
    rd_word                = '0;
    rd_word[TAG_WIDTH-1:0] = operand_a_tag_i & operand_b_i[TAG_WIDTH-1:0];
  end

  // ---- control: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    accept_state = S_RESP;
`ifdef DIFT_TAG_BULK_EN
    if (op_bulk) accept_state = S_WALK;
`endif
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = accept_state;
`ifdef DIFT_TAG_BULK_EN
      S_WALK: if (walk_last) state_d = S_RESP;
`endif
      S_RESP: if (ex_ready_i) state_d = accept ? accept_state : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

`ifdef DIFT_TAG_BULK_EN
  logic [REG_ADDR_WIDTH-1:0] idx_q, end_q, idx_next, start_idx;
  logic [TAG_WIDTH-1:0]      rf_wmask_p1, rf_wdata_p1;
  logic                      rf_we_p1;

  assign start_idx = operand_a_i[REG_ADDR_WIDTH-1:0];
  assign walk_last = (idx_q == end_q);
  // Explicit wrap so a NUM_REGS that is not a power of two still walks correctly.
  assign idx_next  = (idx_q == REG_ADDR_WIDTH'(NUM_REGS - 1)) ? '0
                                                              : idx_q + REG_ADDR_WIDTH'(1);

  // ---- stage p1: registered tag write port ----
  // idx_q is the index currently presented on the write port; x0 is walked
  // but never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      end_q       <= '0;
      rf_wmask_p1 <= '0;
      rf_wdata_p1 <= '0;
      rf_we_p1    <= 1'b0;
    end else if (accept && op_bulk) begin
      idx_q       <= start_idx;
      end_q       <= operand_b_i[REG_ADDR_WIDTH-1:0];
      rf_wmask_p1 <= operand_c_i[TAG_WIDTH-1:0];
      rf_wdata_p1 <= operand_c_i[TAG_WIDTH+7:8];
      rf_we_p1    <= (start_idx != '0);
    end else if ((state_q == S_WALK) && !flush_i && !walk_last) begin
      idx_q    <= idx_next;
      rf_we_p1 <= (idx_next != '0);
    end else begin
      rf_we_p1 <= 1'b0;
    end
  end

  // A flush must suppress the write already staged for this cycle.
  assign rf_tag_we_o    = rf_we_p1 & ~flush_i;
  assign rf_tag_waddr_o = idx_q;
  assign rf_tag_wdata_o = rf_wdata_p1;
  assign rf_tag_wmask_o = rf_wmask_p1;
`else
  assign walk_last      = 1'b0;
  assign rf_tag_we_o    = 1'b0;
  assign rf_tag_waddr_o = '0;
  assign rf_tag_wdata_o = '0;
  assign rf_tag_wmask_o = '0;
`endif

  // ---- stage p1: registered result ----
  // For TAGBULK the result register doubles as the write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p1     <= '0;
      result_tag_p1 <= '0;
      illegal_p1    <= 1'b0;
    end else if (accept) begin
      illegal_p1    <= op_illegal;
      result_tag_p1 <= '0;
      result_p1     <= '0;
      if (operator_i == OP_TAGSET) begin
        result_p1     <= operand_c_i;
        result_tag_p1 <= set_tag;
      end else if (operator_i == OP_TAGRD) begin
        result_p1 <= rd_word;
      end
`ifdef DIFT_TAG_BULK_EN
      else if (op_bulk) begin
        result_p1 <= {31'd0, (start_idx != '0)};
      end
`endif
    end
`ifdef DIFT_TAG_BULK_EN
    else if ((state_q == S_WALK) && !flush_i && !walk_last) begin
      result_p1 <= result_p1 + {31'd0, (idx_next != '0)};
    end
`endif
  end

  assign valid_o      = (state_q == S_RESP);
  assign result_o     = result_p1;
  assign result_tag_o = result_tag_p1;
  assign illegal_op_o = illegal_p1;

endmodule

// File: tb/tb_riscv_dift_tag_manip_seq.sv
`timescale 1ns/1ps
module tb_riscv_dift_tag_manip_seq;

  localparam int NREGS = 32;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [2:0]  op;
  logic [31:0] a, b, c;
  logic [7:0]  atag, ctag;
  logic        flush;
  logic        ex_ready;

  logic        ready4, valid4, ill4, we4;
  logic [31:0] res4;
  logic [3:0]  tag4, wdata4, wmask4;
  logic [4:0]  waddr4;

  logic        ready8, valid8, ill8, we8;
  logic [31:0] res8;
  logic [7:0]  tag8, wdata8, wmask8;
  logic [4:0]  waddr8;

  int checks = 0;
  int errors = 0;

  riscv_dift_tag_manip_seq #(.TAG_WIDTH(4), .NUM_REGS(NREGS), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(op),
    .operand_a_i(a), .operand_b_i(b), .operand_c_i(c),
    .operand_a_tag_i(atag[3:0]), .operand_c_tag_i(ctag[3:0]),
    .flush_i(flush), .ex_ready_i(ex_ready),
    .ready_o(ready4), .valid_o(valid4), .result_o(res4), .result_tag_o(tag4),
    .illegal_op_o(ill4), .rf_tag_we_o(we4), .rf_tag_waddr_o(waddr4),
    .rf_tag_wdata_o(wdata4), .rf_tag_wmask_o(wmask4)
  );

  riscv_dift_tag_manip_seq #(.TAG_WIDTH(8), .NUM_REGS(NREGS), .REG_ADDR_WIDTH(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(op),
    .operand_a_i(a), .operand_b_i(b), .operand_c_i(c),
    .operand_a_tag_i(atag), .operand_c_tag_i(ctag),
    .flush_i(flush), .ex_ready_i(ex_ready),
    .ready_o(ready8), .valid_o(valid8), .result_o(res8), .result_tag_o(tag8),
    .illegal_op_o(ill8), .rf_tag_we_o(we8), .rf_tag_waddr_o(waddr8),
    .rf_tag_wdata_o(wdata8), .rf_tag_wmask_o(wmask8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed writes of the 4-bit instance: {addr, data, mask}
  logic [12:0] wr_q[$];
  logic [12:0] exp_wr[$];
  always @(negedge clk) if (we4 === 1'b1) wr_q.push_back({waddr4, wdata4, wmask4});

  // Reference: result of a single-cycle operation at tag width tw.
  function automatic void model(input int tw, input logic [2:0] o,
                                input logic [31:0] ma, mb, mc,
                                input logic [7:0] at, ct,
                                output logic [31:0] r, output logic [7:0] t,
                                output logic il);
    logic [7:0]  wm, m, v;
    logic [31:0] ab;
    wm = 8'((9'd1 << tw) - 9'd1);
    ab = ma | mb;
    m  = ab[7:0] & wm;
    v  = ab[15:8] & wm;
    r  = 32'd0; t = 8'd0; il = 1'b0;
    case (o)
      3'b000:  begin r = mc; t = (v & m) | (ct & ~m & wm); end
      3'b001:  r = {24'd0, at & mb[7:0] & wm};
      default: il = 1'b1;
    endcase
  endfunction

  // Reference: walk plan for TAGBULK on the 4-bit instance.
  task automatic plan_bulk(input int s, input int e, input logic [31:0] mc,
                           output int len, output int nwr);
    int idx;
    exp_wr.delete();
    len = 0; nwr = 0; idx = s;
    for (int k = 0; k < NREGS; k++) begin
      len++;
      if (idx != 0) begin
        nwr++;
        exp_wr.push_back({idx[4:0], mc[11:8], mc[3:0]});
      end
      if (idx == e) break;
      idx = (idx + 1) % NREGS;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one accepting cycle, then scramble operands.
  task automatic issue(input logic [2:0] o, input logic [31:0] ia, ib, ic,
                       input logic [7:0] iat, ict);
    enable = 1'b1; op = o; a = ia; b = ib; c = ic; atag = iat; ctag = ict;
    cycle();
    enable = 1'b0;
    a = $urandom; b = $urandom; c = $urandom;
    atag = 8'($urandom); ctag = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(); cycle();
    checks++;
    if (ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready4); end
    checks++;
    if ({valid4, ill4, res4, tag4} !== 38'd0) begin
      errors++; $display("FAIL reset_result got v=%b i=%b r=%h t=%h want all 0", valid4, ill4, res4, tag4);
    end
    checks++;
    if ({we4, waddr4, wdata4, wmask4} !== 14'd0) begin
      errors++; $display("FAIL reset_rfport got we=%b a=%h d=%h m=%h want all 0", we4, waddr4, wdata4, wmask4);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_tagset();
    logic [31:0] r; logic [7:0] t; logic il;
    model(8, 3'b000, 32'h0000_0A03, 32'd0, 32'h1234_5678, 8'h00, 8'h04, r, t, il);
    issue(3'b000, 32'h0000_0A03, 32'd0, 32'h1234_5678, 8'h00, 8'h04);
    checks++;
    if ({valid4, ill4, res4, tag4} !== {1'b1, 1'b0, 32'h1234_5678, 4'b0110}) begin
      errors++; $display("FAIL tagset_w4 got v=%b i=%b r=%h t=%b want v=1 i=0 r=12345678 t=0110", valid4, ill4, res4, tag4);
    end
    checks++;
    if ({valid8, res8, tag8} !== {1'b1, r, t}) begin
      errors++; $display("FAIL tagset_w8 got v=%b r=%h t=%h want v=1 r=%h t=%h", valid8, res8, tag8, r, t);
    end
    cycle();
    checks++;
    if (valid4 !== 1'b0) begin errors++; $display("FAIL tagset_release got valid=%b want 0", valid4); end
  endtask

  task automatic test_tagrd_w8();
    issue(3'b001, 32'h0, 32'h0000_000F, 32'hDEAD_BEEF, 8'hA5, 8'h3C);
    checks++;
    if ({valid8, ill8, res8, tag8} !== {1'b1, 1'b0, 32'h0000_0005, 8'h00}) begin
      errors++; $display("FAIL tagrd_w8 got v=%b i=%b r=%h t=%h want v=1 i=0 r=00000005 t=00", valid8, ill8, res8, tag8);
    end
    checks++;
    if ({res4, tag4} !== {32'h0000_0005, 4'h0}) begin
      errors++; $display("FAIL tagrd_w4 got r=%h t=%h want r=00000005 t=0", res4, tag4);
    end
    cycle();
  endtask

  // Random back-to-back stream of single-cycle operations.
  task automatic test_back_to_back();
    logic [31:0] r4, r8; logic [7:0] t4, t8; logic i4, i8;
    logic [2:0]  o;
    wr_q.delete();
    ex_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      o = 3'($urandom_range(0, 7));
`ifdef DIFT_TAG_BULK_EN
      if (o == 3'b010) o = 3'b001;
`endif
      enable = 1'b1; op = o; a = $urandom; b = $urandom; c = $urandom;
      atag = 8'($urandom); ctag = 8'($urandom);
      model(4, o, a, b, c, atag, ctag, r4, t4, i4);
      model(8, o, a, b, c, atag, ctag, r8, t8, i8);
      checks++;
      if (ready4 !== 1'b1) begin errors++; $display("FAIL b2b_ready n=%0d got=%b want 1", n, ready4); end
      cycle();
      checks++;
      if ({valid4, ill4, res4, tag4} !== {1'b1, i4, r4, t4[3:0]}) begin
        errors++; $display("FAIL b2b_w4 n=%0d op=%0d got v=%b i=%b r=%h t=%h want v=1 i=%b r=%h t=%h",
                           n, o, valid4, ill4, res4, tag4, i4, r4, t4[3:0]);
      end
      checks++;
      if ({valid8, ill8, res8, tag8} !== {1'b1, i8, r8, t8}) begin
        errors++; $display("FAIL b2b_w8 n=%0d op=%0d got v=%b i=%b r=%h t=%h want v=1 i=%b r=%h t=%h",
                           n, o, valid8, ill8, res8, tag8, i8, r8, t8);
      end
    end
    enable = 1'b0;
    cycle();
    checks++;
    if (valid4 !== 1'b0) begin errors++; $display("FAIL b2b_drain got valid=%b want 0", valid4); end
    checks++;
    if (wr_q.size() !== 0) begin errors++; $display("FAIL b2b_nowrites got writes=%0d want 0", wr_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r, r2; logic [7:0] t, t2; logic il;
    logic [31:0] na, nb, nc; logic [7:0] nat, nct;
    ex_ready = 1'b0;
    a = $urandom; b = $urandom; atag = 8'($urandom);
    model(4, 3'b001, a, b, 32'd0, atag, 8'd0, r, t, il);
    issue(3'b001, a, b, $urandom, atag, 8'($urandom));
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({valid4, ready4, res4, tag4} !== {1'b1, 1'b0, r, 4'h0}) begin
        errors++; $display("FAIL hold k=%0d got v=%b rdy=%b r=%h t=%h want v=1 rdy=0 r=%h t=0", k, valid4, ready4, res4, tag4, r);
      end
      if (k < 2) cycle();
      else begin
        @(posedge clk); #1;
      end
    end
    na = $urandom; nb = $urandom; nc = $urandom; nat = 8'($urandom); nct = 8'($urandom);
    model(4, 3'b000, na, nb, nc, nat, nct, r2, t2, il);
    ex_ready = 1'b1; enable = 1'b1; op = 3'b000;
    a = na; b = nb; c = nc; atag = nat; ctag = nct;
    #1;
    checks++;
    if ({valid4, ready4} !== 2'b11) begin errors++; $display("FAIL hold_release got v=%b rdy=%b want 11", valid4, ready4); end
    cycle();
    enable = 1'b0;
    checks++;
    if ({valid4, res4, tag4} !== {1'b1, r2, t2[3:0]}) begin
      errors++; $display("FAIL hold_next got v=%b r=%h t=%h want v=1 r=%h t=%h", valid4, res4, tag4, r2, t2[3:0]);
    end
    cycle();
  endtask

  task automatic test_flush_resp();
    ex_ready = 1'b0;
    issue(3'b000, $urandom, $urandom, $urandom, 8'($urandom), 8'($urandom));
    flush = 1'b1; enable = 1'b1; op = 3'b001;
    cycle();
    flush = 1'b0; enable = 1'b0;
    checks++;
    if ({valid4, ready4} !== 2'b01) begin errors++; $display("FAIL flush_resp got v=%b rdy=%b want v=0 rdy=1", valid4, ready4); end
    cycle();
    checks++;
    if (valid4 !== 1'b0) begin errors++; $display("FAIL flush_dominates got valid=%b want 0", valid4); end
    ex_ready = 1'b1;
  endtask

  task automatic test_illegal();
    wr_q.delete();
    issue(3'b111, $urandom, $urandom, $urandom, 8'($urandom), 8'($urandom));
    checks++;
    if ({valid4, ill4, res4, tag4} !== {1'b1, 1'b1, 32'd0, 4'd0}) begin
      errors++; $display("FAIL illegal_111 got v=%b i=%b r=%h t=%h want v=1 i=1 r=0 t=0", valid4, ill4, res4, tag4);
    end
    cycle();
`ifndef DIFT_TAG_BULK_EN
    issue(3'b010, 32'd1, 32'd9, 32'h0000_0F0F, 8'd0, 8'd0);
    checks++;
    if ({valid4, ill4, res4, tag4} !== {1'b1, 1'b1, 32'd0, 4'd0}) begin
      errors++; $display("FAIL illegal_bulk got v=%b i=%b r=%h t=%h want v=1 i=1 r=0 t=0", valid4, ill4, res4, tag4);
    end
    cycle(); cycle();
`endif
    checks++;
    if (wr_q.size() !== 0) begin errors++; $display("FAIL illegal_nowrites got writes=%0d want 0", wr_q.size()); end
  endtask

`ifdef DIFT_TAG_BULK_EN
  task automatic run_bulk(input string name, input int s, input int e, input logic [31:0] mc);
    int len, nwr, k;
    plan_bulk(s, e, mc, len, nwr);
    wr_q.delete();
    issue(3'b010, 32'(s), 32'(e), mc, 8'($urandom), 8'($urandom));
    k = 0;
    while (valid4 !== 1'b1 && k < 64) begin cycle(); k++; end
    checks++;
    if (k !== len) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", name, k, len); end
    checks++;
    if ({valid4, ill4, res4, tag4} !== {1'b1, 1'b0, 32'(nwr), 4'd0}) begin
      errors++; $display("FAIL %s_result got v=%b i=%b r=%0d t=%h want v=1 i=0 r=%0d t=0", name, valid4, ill4, res4, tag4, nwr);
    end
    checks++;
    if (wr_q != exp_wr) begin
      errors++; $display("FAIL %s_writes got count=%0d want count=%0d (contents differ)", name, wr_q.size(), exp_wr.size());
    end
    cycle();
  endtask

  task automatic test_bulk();
    run_bulk("bulk_wrap", 30, 2, 32'h0000_0101);
    checks++;
    if (wr_q.size() !== 4 || wr_q[0] !== {5'd30, 4'd1, 4'd1} || wr_q[3] !== {5'd2, 4'd1, 4'd1}) begin
      errors++; $display("FAIL bulk_wrap_direct got count=%0d want 4 writes 30,31,1,2", wr_q.size());
    end
    run_bulk("bulk_single_x0", 0, 0, 32'h0000_0F0F);
    for (int n = 0; n < 6; n++)
      run_bulk("bulk_rand", $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
  endtask

  task automatic test_flush_walk();
    logic seen;
    wr_q.delete();
    issue(3'b010, 32'd3, 32'd10, 32'h0000_0505, 8'd0, 8'd0);
    cycle(); cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if ({valid4, ready4} !== 2'b01) begin errors++; $display("FAIL flush_walk_ready got v=%b rdy=%b want v=0 rdy=1", valid4, ready4); end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (valid4 === 1'b1) seen = 1'b1;
      cycle();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush_walk_valid got valid seen=%b want 0", seen); end
    checks++;
    if (wr_q.size() !== 2 || wr_q[0] !== {5'd3, 4'd5, 4'd5} || wr_q[1] !== {5'd4, 4'd5, 4'd5}) begin
      errors++; $display("FAIL flush_walk_writes got count=%0d want 2 writes at 3,4", wr_q.size());
    end
  endtask

  task automatic test_reset_mid_walk();
    logic seen;
    wr_q.delete();
    issue(3'b010, 32'd1, 32'd20, 32'h0000_0303, 8'd0, 8'd0);
    cycle(); cycle();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({we4, valid4, ready4} !== 3'b001) begin
      errors++; $display("FAIL reset_walk got we=%b v=%b rdy=%b want we=0 v=0 rdy=1", we4, valid4, ready4);
    end
    cycle();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (valid4 === 1'b1) seen = 1'b1;
      cycle();
    end
    checks++;
    if (seen !== 1'b0 || wr_q.size() !== 2) begin
      errors++; $display("FAIL reset_walk_after got valid seen=%b writes=%0d want 0 and 2", seen, wr_q.size());
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; enable = 1'b0; op = 3'b000; a = '0; b = '0; c = '0;
    atag = '0; ctag = '0; flush = 1'b0; ex_ready = 1'b1;
    #1;
    test_reset();
    test_tagset();
    test_tagrd_w8();
    test_back_to_back();
    test_backpressure();
    test_flush_resp();
    test_illegal();
`ifdef DIFT_TAG_BULK_EN
    test_bulk();
    test_flush_walk();
    test_reset_mid_walk();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_dift_tag_manip_seq.md
# riscv_dift_tag_manip_seq

Sequential, parametrised DIFT tag manipulation unit for the CV32E40P EX stage.
- Executes the custom tag instructions TAGSET and TAGRD for any tag width from 1 to 8 bits, with a registered valid/ready result interface.
- Adds a bulk operation, TAGBULK, that walks a range of register-file tag entries through a dedicated tag write port, one entry per cycle.
- Sits beside the ALU/MULT units and feeds the EX-stage result mux.

## Interface
Parameters:
- TAG_WIDTH, 4, tag bits per register; legal range 1..8
- NUM_REGS, 32, register-file entries covered by TAGBULK
- REG_ADDR_WIDTH, 5, register index width; must equal clog2(NUM_REGS)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- enable_i  in  1  operation request
- operator_i  in  3  TAGSET=3'b000, TAGRD=3'b001, TAGBULK=3'b010; all other codes are illegal
- operand_a_i, operand_b_i, operand_c_i  in  32 each  operands
- operand_a_tag_i, operand_c_tag_i  in  TAG_WIDTH each  operand tags
- flush_i  in  1  pipeline flush
- ex_ready_i  in  1  downstream accepts the result
- ready_o  out  1  unit accepts a request
- valid_o  out  1  result valid
- result_o  out  32  result data
- result_tag_o  out  TAG_WIDTH  result tag
- illegal_op_o  out  1  qualifies valid_o; set when the accepted operator was illegal
- rf_tag_we_o  out  1  tag write enable
- rf_tag_waddr_o  out  REG_ADDR_WIDTH  tag write index
- rf_tag_wdata_o  out  TAG_WIDTH  tag write data
- rf_tag_wmask_o  out  TAG_WIDTH  per-bit write mask; the register file updates only bits where the mask is 1

## Operation
Field layout for every mask/value pair:
- mask = bits [TAG_WIDTH-1:0]
- values = bits [TAG_WIDTH+7:8]

TAGSET:
- mask = a|b, values = a|b (combined over the fields above).
- result_o = operand_c_i.
- result_tag_o bit i = mask[i] ? values[i] : operand_c_tag_i[i].

TAGRD:
- result_o = zero-extended (operand_a_tag_i & operand_b_i[TAG_WIDTH-1:0]).
- result_tag_o = 0.

TAGBULK:
- start = operand_a_i[REG_ADDR_WIDTH-1:0]; end = operand_b_i[REG_ADDR_WIDTH-1:0].
- mask and values are taken from operand_c_i.
- Index advances by one modulo NUM_REGS, from start to end inclusive. If end < start, the walk wraps past NUM_REGS-1 to 0.
- Index 0 (x0) consumes a cycle but never writes: rf_tag_we_o=0 for that index.
- Final response: result_o = number of writes performed; result_tag_o = 0.

Illegal operator:
- One-cycle response with result_o=0, result_tag_o=0, illegal_op_o=1.
- No register-file writes.

State machine (IDLE, WALK, RESP):
- IDLE: accept when enable_i & ready_o. TAGSET, TAGRD and illegal codes go to RESP. TAGBULK goes to WALK.
- WALK: one write (or x0 skip) per cycle. After the end index, go to RESP.
- RESP: valid_o=1. When ex_ready_i is high, go back to IDLE, or accept a new request in the same cycle (back-to-back).
- ready_o = (state==IDLE) | (state==RESP & ex_ready_i).

Flush:
- flush_i in any state returns to IDLE in the next cycle and drops valid_o.
- In WALK, rf_tag_we_o is forced 0 in the flush cycle. Writes already performed are not undone.
- flush_i dominates enable_i in the same cycle.

## Timing
- Reset values: state=IDLE; ready_o=1; valid_o=0; illegal_op_o=0; result_o=0; result_tag_o=0; rf_tag_we_o=0; rf_tag_waddr_o=0; rf_tag_wdata_o=0; rf_tag_wmask_o=0.
- Reset asserted mid-WALK aborts immediately; no further writes.
- TAGSET, TAGRD, illegal: accepted in cycle N, valid_o high in N+1. The response is held stable until ex_ready_i.
- TAGBULK: accepted in cycle N; writes occur in cycles N+1 .. N+L, where L = ((end-start) mod NUM_REGS)+1. valid_o is high in N+L+1.
- rf_tag_* outputs are registered; each write is visible one cycle after its index is computed.
- Operands are sampled only at acceptance. Inputs may change during WALK.

## Configuration
- DIFT_TAG_BULK_EN defined: TAGBULK is implemented as specified above.
- DIFT_TAG_BULK_EN undefined:
  - The WALK state and write-port logic are removed.
  - TAGBULK is treated as an illegal operator.
  - rf_tag_we_o, rf_tag_waddr_o, rf_tag_wdata_o and rf_tag_wmask_o are tied to 0.

## Test plan
- TAGSET, TAG_WIDTH=4: a=0x0000_0A03, b=0, c=0x1234_5678, c_tag=4'b0100 -> result_o=0x1234_5678, result_tag_o=4'b0110, valid_o one cycle after accept.
- TAGRD, TAG_WIDTH=8: a_tag=8'hA5, b=0x0F -> result_o=0x0000_0005, result_tag_o=0.
- TAGBULK: start=30, end=2, c=0x0000_0101, NUM_REGS=32 -> 5 walk cycles at indices 30,31,0,1,2; no write at index 0; 4 writes with wmask=1, wdata=1; result_o=4.
- TAGBULK 3..10, flush_i in the third walk cycle -> exactly 2 writes (indices 3,4); valid_o never asserted; ready_o=1 the next cycle.
- ex_ready_i low for 3 cycles after a TAGRD response -> valid_o and result_o held; ready_o=0; new request accepted in the cycle ex_ready_i rises.
- operator_i=3'b111, or TAGBULK with DIFT_TAG_BULK_EN undefined -> valid_o=1, illegal_op_o=1, result_o=0, rf_tag_we_o never asserted.
